// File: rtl/cpu_pkg.sv
// Shared CPU types for the flag/branch resolution logic.
//   br_type_t : branch kind carried with the EX instruction
//   cond_t    : 4-bit LEGv8 condition field and its named encodings
//   nzcv_t    : condition flags {n,z,c,v}, bit 3 = N ... bit 0 = V
package cpu_pkg;

    typedef enum logic [1:0] {
        BR_COND = 2'd0,
        BR_CBZ  = 2'd1,
        BR_CBNZ = 2'd2,
        BR_RSVD = 2'd3
    } br_type_t;

    typedef logic [3:0] cond_t;

    localparam cond_t COND_EQ = 4'h0;
    localparam cond_t COND_NE = 4'h1;
    localparam cond_t COND_HS = 4'h2;
    localparam cond_t COND_LO = 4'h3;
    localparam cond_t COND_MI = 4'h4;
    localparam cond_t COND_PL = 4'h5;
    localparam cond_t COND_VS = 4'h6;
    localparam cond_t COND_VC = 4'h7;
    localparam cond_t COND_HI = 4'h8;
    localparam cond_t COND_LS = 4'h9;
    localparam cond_t COND_GE = 4'hA;
    localparam cond_t COND_LT = 4'hB;
    localparam cond_t COND_GT = 4'hC;
    localparam cond_t COND_LE = 4'hD;
    localparam cond_t COND_AL = 4'hE;
    localparam cond_t COND_NV = 4'hF;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational LEGv8 condition evaluator.
//   i_flags : NZCV to test
//   i_cond  : condition field
//   o_taken : 1 when the condition holds (AL and NV always hold)
module cond_eval
    import cpu_pkg::*;
(
    input  nzcv_t i_flags,
    input  cond_t i_cond,
    output logic  o_taken
);

    logic w_ge;

    assign w_ge = (i_flags.n == i_flags.v);

    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            COND_EQ: o_taken =  i_flags.z;
            COND_NE: o_taken = ~i_flags.z;
            COND_HS: o_taken =  i_flags.c;
            COND_LO: o_taken = ~i_flags.c;
            COND_MI: o_taken =  i_flags.n;
            COND_PL: o_taken = ~i_flags.n;
            COND_VS: o_taken =  i_flags.v;
            COND_VC: o_taken = ~i_flags.v;
            COND_HI: o_taken =  i_flags.c & ~i_flags.z;
            COND_LS: o_taken = ~i_flags.c |  i_flags.z;
            COND_GE: o_taken =  w_ge;
            COND_LT: o_taken = ~w_ge;
            COND_GT: o_taken = ~i_flags.z &  w_ge;
            COND_LE: o_taken =  i_flags.z | ~w_ge;
            COND_AL: o_taken = 1'b1;
            COND_NV: o_taken = 1'b1;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_unit.sv
// Condition-flag register and branch resolution, downstream of the EX ALU.
//   clk, reset_n            : clock, async active-low reset
//   ex_valid, set_flags     : EX instruction present / writes NZCV
//   alu_result/carry/overflow : ALU outputs used to derive NZCV
//   br_valid, br_type, br_cond, br_reg : conditional branch in EX
//   stall, flush            : hold all state / squash EX (flush wins)
//   flags                   : registered {N,Z,C,V}
//   br_done, br_taken       : registered one-cycle branch decision
module flag_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ex_valid,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             br_valid,
    input  logic [1:0]       br_type,
    input  logic [3:0]       br_cond,
    input  logic [WIDTH-1:0] br_reg,
    input  logic             stall,
    input  logic             flush,
    output logic [3:0]       flags,
    output logic             br_done,
    output logic             br_taken
);

    nzcv_t r_flags;
    logic  r_br_done;
    logic  r_br_taken;

    nzcv_t w_fresh;
    nzcv_t w_eff;
    logic  w_cond_taken;
    logic  w_br_taken;

    always_comb begin
        w_fresh.n = alu_result[WIDTH-1];
        w_fresh.z = ~|alu_result;
        w_fresh.c = alu_carry;
        w_fresh.v = alu_overflow;
    end

    // Bypass lets a flag-setting op and a B.cond resolve in the same cycle.
    assign w_eff = (ex_valid & set_flags) ? w_fresh : r_flags;

    cond_eval u_cond_eval (
        .i_flags (w_eff),
        .i_cond  (cond_t'(br_cond)),
        .o_taken (w_cond_taken)
    );

    always_comb begin
        w_br_taken = 1'b0;
        case (br_type_t'(br_type))
            BR_COND: w_br_taken = w_cond_taken;
            BR_CBZ:  w_br_taken = ~|br_reg;
            BR_CBNZ: w_br_taken =  |br_reg;
            BR_RSVD: w_br_taken = 1'b0;
        endcase
    end

    // Flush is checked before stall so a squashed EX can still clear a
    // decision that a stall would otherwise keep pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flags    <= '0;
            r_br_done  <= 1'b0;
            r_br_taken <= 1'b0;
        end else if (flush) begin
            r_br_done  <= 1'b0;
            r_br_taken <= 1'b0;
        end else if (!stall) begin
            if (ex_valid && set_flags) begin
                r_flags <= w_fresh;
            end
            r_br_done  <= br_valid;
            r_br_taken <= br_valid & w_br_taken;
        end
    end

    assign flags    = r_flags;
    assign br_done  = r_br_done;
    assign br_taken = r_br_taken;

endmodule

// File: tb/tb_flag_unit.sv
module tb_flag_unit;

    logic        clk;
    logic        reset_n;
    logic        ex_valid;
    logic        set_flags;
    logic [63:0] alu_result;
    logic        alu_carry;
    logic        alu_overflow;
    logic        br_valid;
    logic [1:0]  br_type;
    logic [3:0]  br_cond;
    logic [63:0] br_reg;
    logic        stall;
    logic        flush;
    logic [3:0]  flags;
    logic        br_done;
    logic        br_taken;

    int n_checks = 0;
    int n_pass   = 0;

    flag_unit #(.WIDTH(64)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ex_valid     (ex_valid),
        .set_flags    (set_flags),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .br_valid     (br_valid),
        .br_type      (br_type),
        .br_cond      (br_cond),
        .br_reg       (br_reg),
        .stall        (stall),
        .flush        (flush),
        .flags        (flags),
        .br_done      (br_done),
        .br_taken     (br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic        ev, sf;
        logic [63:0] res;
        logic        c, v, bv;
        logic [1:0]  bt;
        logic [3:0]  bc;
        logic [63:0] br;
        logic        st, fl;
        logic [3:0]  ef;
        logic        ed, et;
        string       name;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(string name, logic ev, logic sf, logic [63:0] res,
                                logic c, logic v, logic bv, logic [1:0] bt,
                                logic [3:0] bc, logic [63:0] br, logic st, logic fl,
                                logic [3:0] ef, logic ed, logic et);
        vec_t x;
        x.name = name; x.ev = ev; x.sf = sf; x.res = res; x.c = c; x.v = v;
        x.bv = bv; x.bt = bt; x.bc = bc; x.br = br; x.st = st; x.fl = fl;
        x.ef = ef; x.ed = ed; x.et = et;
        return x;
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic drive(logic ev, logic sf, logic [63:0] res, logic c, logic v,
                         logic bv, logic [1:0] bt, logic [3:0] bc, logic [63:0] br,
                         logic st, logic fl);
        ex_valid = ev; set_flags = sf; alu_result = res; alu_carry = c;
        alu_overflow = v; br_valid = bv; br_type = bt; br_cond = bc; br_reg = br;
        stall = st; flush = fl;
    endtask

    task automatic idle();
        drive(0, 0, 64'd0, 0, 0, 0, 2'd0, 4'd0, 64'd0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference condition check, arranged the way the ARM condition field is
    // defined: bits [3:1] pick a base test, bit 0 inverts it (except 1111).
    function automatic logic ref_cond(logic [3:0] f, logic [3:0] cond);
        logic n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (cond[0] && cond != 4'hF) base = !base;
        return base;
    endfunction

    logic [3:0] m_flags;
    logic       m_done, m_taken;

    task automatic model_step();
        logic [3:0] fresh, eff;
        logic       t;
        fresh = {alu_result[63], alu_result == 64'd0, alu_carry, alu_overflow};
        eff   = (ex_valid && set_flags) ? fresh : m_flags;
        if (br_type == 2'd0)      t = ref_cond(eff, br_cond);
        else if (br_type == 2'd1) t = (br_reg == 64'd0);
        else if (br_type == 2'd2) t = (br_reg != 64'd0);
        else                      t = 1'b0;
        if (flush) begin
            m_done = 0; m_taken = 0;
        end else if (!stall) begin
            if (ex_valid && set_flags) m_flags = fresh;
            m_done  = br_valid;
            m_taken = br_valid && t;
        end
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        #3;
        chk("reset_flags", flags, 4'b0000);
        chk("reset_done", br_done, 1'b0);
        chk("reset_taken", br_taken, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        //         name       ev sf res   c v bv bt    bc     br   st fl  ef       ed et
        vt.push_back(mk("subs_beq", 1,1,64'd0,1,0, 1,2'd0,4'h0,64'd0,0,0, 4'b0110,1,1));
        vt.push_back(mk("idle",     0,0,64'd0,0,0, 0,2'd0,4'h0,64'd0,0,0, 4'b0110,0,0));
        vt.push_back(mk("adds_neg", 1,1,MSB,  0,0, 0,2'd0,4'h0,64'd0,0,0, 4'b1000,0,0));
        vt.push_back(mk("b_ge",     0,0,64'd0,0,0, 1,2'd0,4'hA,64'd0,0,0, 4'b1000,1,0));
        vt.push_back(mk("b_lt",     0,0,64'd0,0,0, 1,2'd0,4'hB,64'd0,0,0, 4'b1000,1,1));
        vt.push_back(mk("cbz_msb",  0,0,64'd0,0,0, 1,2'd1,4'h0,MSB,  0,0, 4'b1000,1,0));
        vt.push_back(mk("cbnz_msb", 0,0,64'd0,0,0, 1,2'd2,4'h0,MSB,  0,0, 4'b1000,1,1));
        vt.push_back(mk("rsvd",     0,0,64'd0,0,0, 1,2'd3,4'hE,64'd0,0,0, 4'b1000,1,0));
        vt.push_back(mk("b_al",     0,0,64'd0,0,0, 1,2'd0,4'hE,64'd0,0,0, 4'b1000,1,1));
        vt.push_back(mk("b_nv",     0,0,64'd0,0,0, 1,2'd0,4'hF,64'd0,0,0, 4'b1000,1,1));
        vt.push_back(mk("flush_all",1,1,ONES, 1,1, 1,2'd0,4'hE,64'd0,1,1, 4'b1000,0,0));
        vt.push_back(mk("adds_bvs", 1,1,64'd5,1,1, 1,2'd0,4'h6,64'd0,0,0, 4'b0011,1,1));
        vt.push_back(mk("b_hi",     0,0,64'd0,0,0, 1,2'd0,4'h8,64'd0,0,0, 4'b0011,1,1));
        vt.push_back(mk("b_gt",     0,0,64'd0,0,0, 1,2'd0,4'hC,64'd0,0,0, 4'b0011,1,0));
        vt.push_back(mk("b_le",     0,0,64'd0,0,0, 1,2'd0,4'hD,64'd0,0,0, 4'b0011,1,1));
        vt.push_back(mk("sf_noev",  0,1,64'd0,0,0, 1,2'd0,4'h0,64'd0,0,0, 4'b0011,1,0));

        foreach (vt[i]) begin
            drive(vt[i].ev, vt[i].sf, vt[i].res, vt[i].c, vt[i].v, vt[i].bv,
                  vt[i].bt, vt[i].bc, vt[i].br, vt[i].st, vt[i].fl);
            tick();
            chk({vt[i].name, "_flags"}, flags, vt[i].ef);
            chk({vt[i].name, "_done"}, br_done, vt[i].ed);
            chk({vt[i].name, "_taken"}, br_taken, vt[i].et);
        end

        // Stall holds a pending decision; an ADDS during the stall is ignored.
        drive(0, 0, 64'd0, 0, 0, 1, 2'd0, 4'h1, 64'd0, 0, 0);
        tick();
        chk("stall_acc_done", br_done, 1'b1);
        chk("stall_acc_taken", br_taken, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 64'd0, 0, 0, 0, 2'd0, 4'h0, 64'd0, 1, 0);
            tick();
            chk("stall_done", br_done, 1'b1);
            chk("stall_taken", br_taken, 1'b1);
            chk("stall_flags", flags, 4'b0011);
        end
        idle();
        tick();
        chk("stall_end_done", br_done, 1'b0);
        chk("stall_end_flags", flags, 4'b0011);

        // Asynchronous reset mid-cycle with flags = 1010 and a pending decision.
        drive(1, 1, MSB, 1, 0, 1, 2'd0, 4'h4, 64'd0, 0, 0);
        tick();
        chk("pre_rst_flags", flags, 4'b1010);
        chk("pre_rst_done", br_done, 1'b1);
        idle();
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_flags", flags, 4'b0000);
        chk("async_rst_done", br_done, 1'b0);
        chk("async_rst_taken", br_taken, 1'b0);
        #2;
        reset_n = 1'b1;
        tick();
        chk("post_rst_flags", flags, 4'b0000);
        chk("post_rst_done", br_done, 1'b0);

        // Randomized traffic against the reference model.
        m_flags = 4'b0000; m_done = 1'b0; m_taken = 1'b0;
        for (int k = 0; k < 400; k++) begin
            logic [63:0] r;
            case ($urandom_range(0, 3))
                0: r = 64'd0;
                1: r = ONES;
                2: r = MSB | {32'd0, $urandom()};
                default: r = {$urandom(), $urandom()};
            endcase
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, r,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 2) == 0) ? 64'd0 : {$urandom(), $urandom()},
                  $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
            model_step();
            tick();
            chk("rnd_flags", flags, m_flags);
            chk("rnd_done", br_done, m_done);
            chk("rnd_taken", br_taken, m_taken);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
